// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Burst counter must be able to hold the value MAX_BURST itself.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; master is the arbiter's view.
// Handshake: a word on reqData slice i is consumed on a rising edge where grant[i] & write are both high.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int width   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       last;
  logic [NUM_REQ*width-1:0] reqData;
  logic                     full;
  logic [NUM_REQ-1:0]       grant;
  logic                     write;
  logic [width-1:0]         inputBus;
  logic                     busy;

  modport master (
    input  req, last, reqData, full,
    output grant, write, inputBus, busy
  );

  modport slave (
    output req, last, reqData, full,
    input  grant, write, inputBus, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req scanning upward from ptr+1 with wrap.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);
  logic [IDX_W-1:0] sel;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sel    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[sel]) begin
        winner[sel] = 1'b1;
        valid       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded owner of the FIFO write port for NUM_REQ producers.
// Optional FIFO_ARB_STATS_EN adds a saturating 16-bit stallCount output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int width     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_wr_arbiter_if.master   bus,
  output arb_state_e          dbg_state
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]         stallCount
`endif
);
  localparam int IDX_W       = $clog2(NUM_REQ);
  localparam int BURST_CNT_W = burst_cnt_w(MAX_BURST);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d;

  logic [IDX_W-1:0]       owner_idx, pick_ptr;
  logic [NUM_REQ-1:0]     pick_req, pick_winner;
  logic                   pick_valid;
  logic                   req_own, last_own, write_w, last_rel, release_w;
  logic [BURST_CNT_W-1:0] burst_inc;
  logic [width-1:0]       data_w;

  assign owner_idx = IDX_W'(onehot_to_idx(8'(grant_q)));
  assign req_own   = |(grant_q & bus.req);
  assign last_own  = |(grant_q & bus.last);
  assign write_w   = req_own & ~bus.full;
  assign burst_inc = burst_q + BURST_CNT_W'(1);
  assign last_rel  = write_w & last_own;
  assign release_w = (state_q == OWN) &
                     (~req_own | last_rel | (write_w & (burst_inc == BURST_CNT_W'(MAX_BURST))));

  // A finished packet gives up its turn; a burst-limited owner may win again if alone.
  assign pick_req = bus.req & ~(grant_q & {NUM_REQ{last_rel}});
  assign pick_ptr = (state_q == OWN) ? owner_idx : ptr_q;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    data_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) data_w = data_w | bus.reqData[i*width +: width];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          grant_d = pick_winner;
          burst_d = '0;
        end
      end
      OWN: begin
        if (release_w) begin
          ptr_d   = owner_idx;
          burst_d = '0;
          grant_d = pick_valid ? pick_winner : '0;
          state_d = pick_valid ? OWN : IDLE;
        end else if (write_w) begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  assign stall_d = (req_own & bus.full & (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stallCount = stall_q;
`endif

  assign bus.grant    = grant_q;
  assign bus.write    = write_w;
  assign bus.inputBus = data_w;
  assign bus.busy     = |grant_q;
  assign dbg_state    = state_q;
endmodule
